// File: rtl/timer_pkg.sv
// Shared types and defaults for the tick timer bank: channel state encoding
// and the default tick divider for a 1 ms tick from a 50 MHz clock.
package timer_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ch_state_t;

    localparam int TICK_DIV_1MS_50MHZ = 50000;
    localparam int DEFAULT_NUM_CH     = 4;
    localparam int DEFAULT_CNT_W      = 16;

endpackage

// File: rtl/tick_timer_bank_if.sv
// Control/status bundle between the game controller and the timer bank.
interface tick_timer_bank_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic                    enable;
    logic                    clear_time;
    logic                    tick;
    logic [NUM_CH-1:0]       ch_load;
    logic [NUM_CH*CNT_W-1:0] ch_value;
    logic [NUM_CH-1:0]       ch_periodic;
    logic [NUM_CH-1:0]       ch_stop;
    logic [NUM_CH-1:0]       ch_busy;
    logic [NUM_CH-1:0]       ch_expire;
    logic [NUM_CH*CNT_W-1:0] ch_count;

    modport master (
        output enable, clear_time, ch_load, ch_value, ch_periodic, ch_stop,
        input  tick, ch_busy, ch_expire, ch_count
    );

    modport slave (
        input  enable, clear_time, ch_load, ch_value, ch_periodic, ch_stop,
        output tick, ch_busy, ch_expire, ch_count
    );
endinterface

// File: rtl/tick_prescaler.sv
// Shared prescaler: emits a registered one-cycle tick every TICK_DIV clocks
// while enabled; disable or clear restarts the count from zero.
module tick_prescaler
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_1MS_50MHZ
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear_time,
    output logic tick
);
    localparam int            PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_reg <= '0;
            tick      <= 1'b0;
        end else if (clear_time || !enable) begin
            presc_reg <= '0;
            tick      <= 1'b0;
        end else if (presc_reg == LAST) begin
            presc_reg <= '0;
            tick      <= 1'b1;
        end else begin
            presc_reg <= presc_reg + 1'b1;
            tick      <= 1'b0;
        end
    end
endmodule

// File: rtl/tick_timer_bank.sv
// Bank of NUM_CH countdown channels sharing one prescaler tick; each channel
// is one-shot or periodic and pulses ch_expire for one cycle on expiry.
module tick_timer_bank
    import timer_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_1MS_50MHZ,
    parameter int NUM_CH   = DEFAULT_NUM_CH,
    parameter int CNT_W    = DEFAULT_CNT_W
) (
    input  logic            clk,
    input  logic            rst,
    tick_timer_bank_if.slave bus
);
    logic tick;

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk        (clk),
        .rst        (rst),
        .enable     (bus.enable),
        .clear_time (bus.clear_time),
        .tick       (tick)
    );

    assign bus.tick = tick;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        ch_state_t        state_reg;
        logic [CNT_W-1:0] count_reg;
        logic [CNT_W-1:0] reload_reg;
        logic             mode_reg;
        logic             expire_reg;
        logic [CNT_W-1:0] load_value;

        assign load_value = bus.ch_value[gi*CNT_W +: CNT_W];

        // Decrement only while count>1, so the counter can never wrap.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                state_reg  <= IDLE;
                count_reg  <= '0;
                reload_reg <= '0;
                mode_reg   <= 1'b0;
                expire_reg <= 1'b0;
            end else begin
                expire_reg <= 1'b0;
                if (bus.clear_time) begin
                    state_reg  <= IDLE;
                    count_reg  <= '0;
                    reload_reg <= '0;
                    mode_reg   <= 1'b0;
                end else if (bus.ch_load[gi]) begin
                    reload_reg <= load_value;
                    mode_reg   <= bus.ch_periodic[gi];
                    count_reg  <= load_value;
                    if (load_value == '0) begin
                        state_reg  <= IDLE;
                        expire_reg <= 1'b1;
                    end else begin
                        state_reg  <= RUN;
                    end
                end else if (bus.ch_stop[gi]) begin
                    state_reg <= IDLE;
                end else if (state_reg == RUN && tick) begin
                    if (count_reg > CNT_W'(1)) begin
                        count_reg <= count_reg - 1'b1;
                    end else begin
                        expire_reg <= 1'b1;
                        if (mode_reg) begin
                            count_reg <= reload_reg;
                        end else begin
                            count_reg <= '0;
                            state_reg <= IDLE;
                        end
                    end
                end
            end
        end

        assign bus.ch_busy[gi]                  = (state_reg == RUN);
        assign bus.ch_expire[gi]                = expire_reg;
        assign bus.ch_count[gi*CNT_W +: CNT_W]  = count_reg;
    end
endmodule

// File: tb/tb_tick_timer_bank.sv
// Scoreboard bench for tick_timer_bank (TICK_DIV=4, NUM_CH=2, CNT_W=8).
module tb_tick_timer_bank;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tick_timer_bank_if #(.NUM_CH(2), .CNT_W(8)) bus ();

    tick_timer_bank #(.TICK_DIV(4), .NUM_CH(2), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic [1:0]  busy;
        logic [15:0] count;
        logic        chk_tick;
        logic        tick;
    } snap_t;

    typedef struct {
        string      name;
        logic [1:0] mask;
    } exp_t;

    snap_t snap_q[$];
    exp_t  exp_q[$];
    int    total = 0;
    int    bad   = 0;

    task automatic snap(input string nm, input logic [1:0] b, input logic [7:0] c1,
                        input logic [7:0] c0, input logic ct, input logic t);
        snap_t s;
        s.name = nm; s.busy = b; s.count = {c1, c0}; s.chk_tick = ct; s.tick = t;
        snap_q.push_back(s);
    endtask

    task automatic expect_expire(input string nm, input logic [1:0] m);
        exp_t e;
        e.name = nm; e.mask = m;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(input string nm);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.tick) return;
        end
        total++;
        bad++;
        $display("FAIL %s: no tick within 20 clocks, want a tick", nm);
    endtask

    // Monitor: compares queued expectations against what the DUT presents.
    always @(negedge clk) begin
        if (snap_q.size() > 0) begin
            snap_t s;
            s = snap_q.pop_front();
            total++;
            if (bus.ch_busy !== s.busy || bus.ch_count !== s.count ||
                (s.chk_tick && bus.tick !== s.tick)) begin
                bad++;
                $display("FAIL %s: got busy=%b count=%h tick=%b, want busy=%b count=%h tick=%b%s",
                         s.name, bus.ch_busy, bus.ch_count, bus.tick, s.busy, s.count,
                         s.tick, s.chk_tick ? "" : "(any)");
            end else begin
                $display("ok   %s: busy=%b count=%h tick=%b", s.name, bus.ch_busy,
                         bus.ch_count, bus.tick);
            end
        end
        if (bus.ch_expire !== 2'b00) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_expire: got ch_expire=%b, want 00", bus.ch_expire);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (bus.ch_expire !== e.mask) begin
                    bad++;
                    $display("FAIL %s: got ch_expire=%b, want %b", e.name, bus.ch_expire, e.mask);
                end else begin
                    $display("ok   %s: ch_expire=%b", e.name, bus.ch_expire);
                end
            end
        end
    end

    initial begin
        bus.enable = 1'b0; bus.clear_time = 1'b0;
        bus.ch_load = 2'b00; bus.ch_value = 16'h0000;
        bus.ch_periodic = 2'b00; bus.ch_stop = 2'b00;
        snap("reset", 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(1);

        // Free-running prescaler: first tick 4 clocks after enable.
        bus.enable = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            snap($sformatf("presc_c%0d", i), 2'b00, 8'd0, 8'd0, 1'b1, (i % 4) == 0);
        end

        // Ch0 one-shot of 3, loaded on a tick edge (that tick is ignored).
        bus.ch_load = 2'b01; bus.ch_value = {8'd0, 8'd3}; bus.ch_periodic = 2'b00;
        expect_expire("ch0_oneshot_expire", 2'b01);
        cyc(1);
        bus.ch_load = 2'b00;
        snap("ch0_load3", 2'b01, 8'd0, 8'd3, 1'b0, 1'b0);
        wait_tick("ch0_t1"); cyc(1); snap("ch0_t1", 2'b01, 8'd0, 8'd2, 1'b0, 1'b0);
        wait_tick("ch0_t2"); cyc(1); snap("ch0_t2", 2'b01, 8'd0, 8'd1, 1'b0, 1'b0);
        wait_tick("ch0_t3"); cyc(1); snap("ch0_t3", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        wait_tick("ch0_idle_a"); wait_tick("ch0_idle_b"); cyc(1);
        snap("ch0_idle", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);

        // Ch1 periodic 2: expiries on ticks 2, 4, 6; stopped after tick 7.
        bus.ch_load = 2'b10; bus.ch_value = {8'd2, 8'd0}; bus.ch_periodic = 2'b10;
        for (int i = 0; i < 3; i++) expect_expire($sformatf("ch1_periodic_exp%0d", i), 2'b10);
        cyc(1);
        bus.ch_load = 2'b00; bus.ch_periodic = 2'b00;
        snap("ch1_load2", 2'b10, 8'd2, 8'd0, 1'b0, 1'b0);
        for (int k = 1; k <= 7; k++) begin
            wait_tick($sformatf("ch1_t%0d", k)); cyc(1);
            snap($sformatf("ch1_t%0d", k), 2'b10, (k % 2) ? 8'd1 : 8'd2, 8'd0, 1'b0, 1'b0);
        end
        bus.ch_stop = 2'b10;
        cyc(1);
        bus.ch_stop = 2'b00;
        snap("ch1_stop", 2'b00, 8'd1, 8'd0, 1'b0, 1'b0);
        wait_tick("ch1_frozen_a"); wait_tick("ch1_frozen_b"); cyc(1);
        snap("ch1_frozen", 2'b00, 8'd1, 8'd0, 1'b0, 1'b0);

        // Load of zero expires immediately without entering RUN.
        bus.ch_load = 2'b01; bus.ch_value = 16'h0000;
        expect_expire("ch0_load0_expire", 2'b01);
        cyc(1);
        bus.ch_load = 2'b00;
        snap("ch0_load0", 2'b00, 8'd1, 8'd0, 1'b0, 1'b0);
        cyc(1);
        snap("ch0_load0_after", 2'b00, 8'd1, 8'd0, 1'b0, 1'b0);

        // Reload coincident with a tick on a running channel: no decrement.
        bus.ch_load = 2'b01; bus.ch_value = {8'd0, 8'd9};
        cyc(1);
        bus.ch_load = 2'b00;
        snap("ch0_load9", 2'b01, 8'd1, 8'd9, 1'b0, 1'b0);
        wait_tick("ch0_pre_reload");
        bus.ch_load = 2'b01; bus.ch_value = {8'd0, 8'd7};
        cyc(1);
        bus.ch_load = 2'b00;
        snap("ch0_reload_on_tick", 2'b01, 8'd1, 8'd7, 1'b0, 1'b0);
        bus.ch_load = 2'b10; bus.ch_value = {8'd10, 8'd0}; bus.ch_periodic = 2'b10;
        cyc(1);
        bus.ch_load = 2'b00; bus.ch_periodic = 2'b00;
        snap("both_run", 2'b11, 8'd10, 8'd7, 1'b0, 1'b0);

        // Global clear, then the prescaler restarts from zero.
        bus.clear_time = 1'b1;
        cyc(1);
        bus.clear_time = 1'b0;
        snap("clear", 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            snap($sformatf("clear_presc_c%0d", i), 2'b00, 8'd0, 8'd0, 1'b1, i == 4);
        end

        // Disable freezes running channels.
        bus.ch_load = 2'b11; bus.ch_value = {8'd3, 8'd5}; bus.ch_periodic = 2'b10;
        cyc(1);
        bus.ch_load = 2'b00; bus.ch_periodic = 2'b00;
        snap("freeze_load", 2'b11, 8'd3, 8'd5, 1'b0, 1'b0);
        wait_tick("freeze_t1"); cyc(1);
        snap("freeze_t1", 2'b11, 8'd2, 8'd4, 1'b0, 1'b0);
        bus.enable = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1);
            snap($sformatf("frozen_c%0d", i), 2'b11, 8'd2, 8'd4, 1'b1, 1'b0);
        end
        bus.enable = 1'b1;
        wait_tick("resume_t1"); cyc(1);
        snap("resume_t1", 2'b11, 8'd1, 8'd3, 1'b0, 1'b0);
        cyc(1);

        // Asynchronous reset mid-count, checked before the next clock edge.
        rst = 1'b0;
        #1;
        snap("async_reset", 2'b00, 8'd0, 8'd0, 1'b1, 1'b0);
        cyc(2);
        rst = 1'b1;
        cyc(3);
        snap("post_reset", 2'b00, 8'd0, 8'd0, 1'b0, 1'b0);
        cyc(2);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL pending_expire: got %0d expiries never seen, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
